// File: rtl/amber128_bundle_packer.sv
// Packs 24-bit and 12-bit instructions into 128-bit amber128 bundles.
// A one-deep output register gives each bundle a word address.
module amber128_bundle_packer #(
  parameter int                ADDR_W          = 32,
  parameter logic [ADDR_W-1:0] RESET_WORD_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_is12_i,
  input  logic [23:0]       in_ins_i,
  input  logic              flush_i,
  output logic              bundle_valid_o,
  input  logic              bundle_ready_i,
  output logic [127:0]      bundle_o,
  output logic [ADDR_W-1:0] bundle_word_addr_o,
  output logic              busy_o
);

  // Slot 0 sits at the MSB end, so the packed order matches the bundle layout.
  // An empty builder holds all-nop pairs (flag 1, payload 0), which is
  // exactly the padding a closed bundle needs.
  logic [0:4][23:0] slots_q, slots_d, slots_t;
  logic [0:4]       flags_q, flags_d, flags_t;
  logic [2:0]       idx_q, idx_d, idx_t;
  logic             half_q, half_d, half_t;
  logic             out_valid_q;
  logic [127:0]     out_bundle_q;
  logic [ADDR_W-1:0] addr_q;

  logic acc, fl_acc, ovf, close, hs;
  logic [127:0] closed_bundle;

  assign in_ready_o         = !out_valid_q || bundle_ready_i;
  assign hs                 = out_valid_q && bundle_ready_i;
  assign acc                = in_valid_i && in_ready_o;
  assign fl_acc             = flush_i && in_ready_o;
  assign bundle_valid_o     = out_valid_q;
  assign bundle_o           = out_bundle_q;
  assign bundle_word_addr_o = addr_q;
  assign busy_o             = (idx_q != 3'd0) || half_q;

  always_comb begin
    slots_t = slots_q;
    flags_t = flags_q;
    idx_t   = idx_q;
    half_t  = half_q;
    ovf     = 1'b0;
    if (acc) begin
      if (in_is12_i) begin
        if (half_t) begin
          slots_t[idx_t][11:0] = in_ins_i[11:0];
          half_t = 1'b0;
          idx_t  = idx_t + 3'd1;
        end else begin
          slots_t[idx_t] = {in_ins_i[11:0], 12'h000};
          flags_t[idx_t] = 1'b1;
          half_t = 1'b1;
        end
      end else begin
        // A 24-bit op seals any open half slot with a nop second half.
        if (half_t) begin
          half_t = 1'b0;
          idx_t  = idx_t + 3'd1;
        end
        if (idx_t == 3'd5) begin
          ovf = 1'b1;
        end else begin
          slots_t[idx_t] = in_ins_i;
          flags_t[idx_t] = 1'b0;
          idx_t = idx_t + 3'd1;
        end
      end
    end
    // On overflow the flush has already been satisfied by this close; the
    // carried instruction stays in the fresh builder.
    close = (idx_t == 3'd5) || (fl_acc && ((idx_t != 3'd0) || half_t));
    closed_bundle = {flags_t, 3'b000, slots_t};

    slots_d = slots_t;
    flags_d = flags_t;
    idx_d   = idx_t;
    half_d  = half_t;
    if (close) begin
      slots_d = '0;
      flags_d = '1;
      idx_d   = 3'd0;
      half_d  = 1'b0;
      if (ovf) begin
        slots_d[0] = in_ins_i;
        flags_d[0] = 1'b0;
        idx_d      = 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slots_q      <= '0;
      flags_q      <= '1;
      idx_q        <= 3'd0;
      half_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_bundle_q <= '0;
      addr_q       <= RESET_WORD_ADDR;
    end else begin
      slots_q <= slots_d;
      flags_q <= flags_d;
      idx_q   <= idx_d;
      half_q  <= half_d;
      if (close) begin
        out_bundle_q <= closed_bundle;
        out_valid_q  <= 1'b1;
      end else if (hs) begin
        out_valid_q  <= 1'b0;
      end
      if (hs) addr_q <= addr_q + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_amber128_bundle_packer.sv
// Self-checking bench: directed bundle scenarios plus randomized traffic
// against a list-based packing model.
module tb_amber128_bundle_packer;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic         in_is12_i = 1'b0;
  logic [23:0]  in_ins_i = '0;
  logic         flush_i = 1'b0;
  logic         bundle_valid_o;
  logic         bundle_ready_i = 1'b0;
  logic [127:0] bundle_o;
  logic [31:0]  bundle_word_addr_o;
  logic         busy_o;

  amber128_bundle_packer #(.ADDR_W(32), .RESET_WORD_ADDR(32'd0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_is12_i(in_is12_i), .in_ins_i(in_ins_i), .flush_i(flush_i),
    .bundle_valid_o(bundle_valid_o), .bundle_ready_i(bundle_ready_i),
    .bundle_o(bundle_o), .bundle_word_addr_o(bundle_word_addr_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_pass = 0;

  // Model: the current bundle is just the list of instructions it holds.
  bit          m_is12[$];
  bit [23:0]   m_ins[$];
  bit [127:0]  exp_b[$];
  bit [31:0]   m_addr = 0;

  logic         obs_rdy, obs_bv, obs_busy;
  logic [127:0] obs_b;
  logic [31:0]  obs_a;
  bit           hs, got_exp, exp_busy;
  bit [127:0]   eb;
  bit [31:0]    ea;

  function automatic bit [127:0] m_pack(output int full, output bit open);
    bit [4:0]  f = 5'b11111;
    bit [23:0] sl [5];
    int s = 0;
    open = 0;
    for (int k = 0; k < 5; k++) sl[k] = '0;
    for (int i = 0; i < m_ins.size(); i++) begin
      if (m_is12[i]) begin
        if (open) begin
          if (s < 5) sl[s][11:0] = m_ins[i][11:0];
          open = 0; s++;
        end else begin
          if (s < 5) begin sl[s] = {m_ins[i][11:0], 12'h000}; f[4-s] = 1'b1; end
          open = 1;
        end
      end else begin
        if (open) begin open = 0; s++; end
        if (s < 5) begin sl[s] = m_ins[i]; f[4-s] = 1'b0; end
        s++;
      end
    end
    full = s;
    return {f, 3'b000, sl[0], sl[1], sl[2], sl[3], sl[4]};
  endfunction

  function automatic void m_close();
    int full; bit open;
    exp_b.push_back(m_pack(full, open));
    m_is12.delete(); m_ins.delete();
  endfunction

  function automatic void model_step(bit v, bit is12, bit [23:0] ins, bit fl);
    int full; bit open; bit ovf = 0;
    if (v) begin
      m_is12.push_back(is12); m_ins.push_back(ins);
      void'(m_pack(full, open));
      if (full + int'(open) > 5) begin
        void'(m_is12.pop_back()); void'(m_ins.pop_back());
        m_close();
        m_is12.push_back(is12); m_ins.push_back(ins);
        ovf = 1;
      end else if (full == 5) begin
        m_close();
      end
    end
    if (fl && !ovf && m_ins.size() > 0) m_close();
  endfunction

  task automatic drive(input bit v, input bit is12, input bit [23:0] ins,
                       input bit fl, input bit br);
    in_valid_i = v; in_is12_i = is12; in_ins_i = ins; flush_i = fl;
    bundle_ready_i = br;
    @(negedge clk_i);
    obs_rdy = in_ready_o; obs_bv = bundle_valid_o; obs_b = bundle_o;
    obs_a = bundle_word_addr_o; obs_busy = busy_o;
    exp_busy = (m_ins.size() > 0);
    hs = obs_bv && br;
    got_exp = 0;
    if (hs && exp_b.size() > 0) begin
      eb = exp_b.pop_front(); ea = m_addr; m_addr++; got_exp = 1;
    end
    if (obs_rdy && (v || fl)) model_step(v, is12, ins, fl);
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    n_chk++; if (bundle_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", bundle_valid_o); else n_pass++;
    n_chk++; if (bundle_o !== 128'd0) $display("FAIL reset_bundle got %h want 0", bundle_o); else n_pass++;
    n_chk++; if (bundle_word_addr_o !== 32'd0) $display("FAIL reset_addr got %h want 0", bundle_word_addr_o); else n_pass++;
    n_chk++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else n_pass++;
    n_chk++; if (in_ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready_o); else n_pass++;
    @(posedge clk_i); #1;
  endtask

  task automatic test_five24();
    bit [127:0] want = {5'b00000, 3'b000, 24'h100001, 24'h100002, 24'h100003, 24'h100004, 24'h100005};
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 24'h100001 + 24'(i), 0, 0);
      n_chk++; if (obs_bv !== 1'b0) $display("FAIL five24_early_valid i=%0d got %b want 0", i, obs_bv); else n_pass++;
    end
    drive(0, 0, 0, 0, 1);
    n_chk++; if (obs_bv !== 1'b1) $display("FAIL five24_valid got %b want 1", obs_bv); else n_pass++;
    n_chk++; if (obs_b !== want) $display("FAIL five24_bundle got %h want %h", obs_b, want); else n_pass++;
    n_chk++; if (obs_a !== 32'd0) $display("FAIL five24_addr got %h want 0", obs_a); else n_pass++;
    n_chk++; if (!got_exp || obs_b !== eb) $display("FAIL five24_model got %h want %h", obs_b, eb); else n_pass++;
  endtask

  task automatic test_ten12();
    bit [127:0] want = {5'b11111, 3'b000, 24'h101102, 24'h103104, 24'h105106, 24'h107108, 24'h10910A};
    for (int i = 0; i < 10; i++) drive(1, 1, 24'h000101 + 24'(i), 0, 1);
    drive(0, 0, 0, 0, 1);
    n_chk++; if (obs_bv !== 1'b1 || obs_b !== want) $display("FAIL ten12_bundle got %b/%h want 1/%h", obs_bv, obs_b, want); else n_pass++;
    n_chk++; if (obs_a !== 32'd1) $display("FAIL ten12_addr got %h want 1", obs_a); else n_pass++;
  endtask

  task automatic test_mixed_flush();
    bit [127:0] want = {5'b10111, 3'b000, 24'h1A0000, 24'h812345, 24'h0, 24'h0, 24'h0};
    drive(1, 1, 24'h0001A0, 0, 1);
    n_chk++; if (obs_busy !== 1'b0) $display("FAIL mixed_busy_before got %b want 0", obs_busy); else n_pass++;
    drive(1, 0, 24'h812345, 0, 1);
    n_chk++; if (obs_busy !== 1'b1) $display("FAIL mixed_busy_half got %b want 1", obs_busy); else n_pass++;
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1);
    n_chk++; if (obs_bv !== 1'b1 || obs_b !== want) $display("FAIL mixed_bundle got %b/%h want 1/%h", obs_bv, obs_b, want); else n_pass++;
    n_chk++; if (obs_a !== 32'd2 || obs_busy !== 1'b0) $display("FAIL mixed_addr_busy got %h/%b want 2/0", obs_a, obs_busy); else n_pass++;
  endtask

  task automatic test_overflow();
    bit [127:0] w0 = {5'b00001, 3'b000, 24'h200001, 24'h200002, 24'h200003, 24'h200004, 24'h301000};
    bit [127:0] w1 = {5'b01111, 3'b000, 24'h900007, 24'h0, 24'h0, 24'h0, 24'h0};
    for (int i = 0; i < 4; i++) drive(1, 0, 24'h200001 + 24'(i), 0, 1);
    drive(1, 1, 24'h000301, 0, 1);
    drive(1, 0, 24'h900007, 0, 1);
    drive(0, 0, 0, 1, 1);
    n_chk++; if (obs_bv !== 1'b1 || obs_b !== w0) $display("FAIL ovf_bundle0 got %b/%h want 1/%h", obs_bv, obs_b, w0); else n_pass++;
    n_chk++; if (obs_a !== 32'd3 || obs_busy !== 1'b1) $display("FAIL ovf_addr0_busy got %h/%b want 3/1", obs_a, obs_busy); else n_pass++;
    drive(0, 0, 0, 0, 1);
    n_chk++; if (obs_bv !== 1'b1 || obs_b !== w1) $display("FAIL ovf_bundle1 got %b/%h want 1/%h", obs_bv, obs_b, w1); else n_pass++;
    n_chk++; if (obs_a !== 32'd4) $display("FAIL ovf_addr1 got %h want 4", obs_a); else n_pass++;
  endtask

  task automatic test_stall();
    bit [127:0] held;
    for (int i = 0; i < 5; i++) drive(1, 0, 24'($urandom), 0, 0);
    drive(1, 0, 24'h777777, 0, 0);
    held = obs_b;
    n_chk++; if (obs_bv !== 1'b1 || obs_rdy !== 1'b0) $display("FAIL stall_start got v=%b r=%b want v=1 r=0", obs_bv, obs_rdy); else n_pass++;
    for (int c = 0; c < 10; c++) begin
      drive(1, 0, 24'h777777, 1, 0);
      n_chk++;
      if (obs_rdy !== 1'b0 || obs_bv !== 1'b1 || obs_b !== held || obs_a !== 32'd5)
        $display("FAIL stall_hold c=%0d got r=%b v=%b %h a=%h want r=0 v=1 %h a=5", c, obs_rdy, obs_bv, obs_b, obs_a, held);
      else n_pass++;
    end
    drive(0, 0, 0, 0, 1);
    n_chk++; if (!got_exp || obs_b !== eb || obs_a !== ea) $display("FAIL stall_release got %h a=%h want %h a=%h", obs_b, obs_a, eb, ea); else n_pass++;
    drive(0, 0, 0, 0, 1);
    n_chk++; if (obs_a !== 32'd6 || obs_bv !== 1'b0) $display("FAIL stall_after got a=%h v=%b want a=6 v=0", obs_a, obs_bv); else n_pass++;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) drive(1, 0, 24'h400000 + 24'(i), 0, 1);
    rst_ni = 1'b0;
    #2;
    n_chk++;
    if (bundle_valid_o !== 1'b0 || bundle_o !== 128'd0 || bundle_word_addr_o !== 32'd0 || busy_o !== 1'b0)
      $display("FAIL midreset_outputs got v=%b b=%h a=%h busy=%b want all 0", bundle_valid_o, bundle_o, bundle_word_addr_o, busy_o);
    else n_pass++;
    @(posedge clk_i); #1 rst_ni = 1'b1;
    m_is12.delete(); m_ins.delete(); exp_b.delete(); m_addr = 0;
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 0, 0, 1);
      n_chk++; if (obs_bv !== 1'b0 || obs_rdy !== 1'b1) $display("FAIL midreset_quiet c=%0d got v=%b r=%b want 0/1", c, obs_bv, obs_rdy); else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), 24'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
      n_chk++; if (obs_busy !== exp_busy) $display("FAIL rand_busy c=%0d got %b want %b", c, obs_busy, exp_busy); else n_pass++;
      if (hs) begin
        n_chk++;
        if (!got_exp || obs_b !== eb || obs_a !== ea)
          $display("FAIL rand_bundle c=%0d got %h a=%h want %h a=%h (model had=%b)", c, obs_b, obs_a, eb, ea, got_exp);
        else n_pass++;
      end
    end
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, 0, 1, 1);
      if (hs) begin
        n_chk++;
        if (!got_exp || obs_b !== eb || obs_a !== ea)
          $display("FAIL rand_drain c=%0d got %h a=%h want %h a=%h", c, obs_b, obs_a, eb, ea);
        else n_pass++;
      end
    end
    n_chk++; if (exp_b.size() != 0 || obs_bv !== 1'b0) $display("FAIL rand_leftover got %0d pending v=%b want 0/0", exp_b.size(), obs_bv); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_five24();
    test_ten12();
    test_mixed_flush();
    test_overflow();
    test_stall();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end

endmodule

// File: doc/amber128_bundle_packer.md
# amber128_bundle_packer

Packs a stream of individual 24-bit and 12-bit instructions into 128-bit amber128 instruction bundles. It is the encoder counterpart of the front-end bundle decoder. The block sits between an instruction source (assembler loader, test injector or trace replayer) and instruction memory or the fetch path. It emits one fully formed bundle per valid/ready handshake, tagged with its bundle word address.

## Interface
- RESET_WORD_ADDR, 0: word address assigned to the first bundle after reset.
- ADDR_W, 32: width of the bundle word address.

- clk_i  in  1  single clock; all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  instruction offered.
- in_ready_o  out  1  instruction/flush accepted this cycle when high.
- in_is12_i  in  1  1 = 12-bit instruction in in_ins_i[11:0]; 0 = 24-bit in in_ins_i[23:0].
- in_ins_i  in  24  instruction payload; [23:12] ignored when in_is12_i=1.
- flush_i  in  1  close the partial bundle after any instruction accepted this cycle.
- bundle_valid_o  out  1  bundle_o holds a complete bundle.
- bundle_ready_i  in  1  downstream consumes bundle this cycle.
- bundle_o  out  128  packed bundle.
- bundle_word_addr_o  out  ADDR_W  word address of bundle_o.
- busy_o  out  1  builder holds at least one packed instruction.

## Operation
- Bundle format:
  - [127:123] flags; flag bit (4-s) = 1 means slot s holds two 12-bit instructions.
  - [122:120] = 0.
  - Slot s occupies [119-24s -: 24], s = 0..4.
  - In a two-12 slot, the first instruction is in [23:12] and the second in [11:0].
- Internal state:
  - builder register of 5 slots plus 5 flags;
  - slot index 0..4;
  - half_open bit, set when a 12-bit slot has only its first half filled;
  - output register plus out_valid;
  - address counter.
- in_ready_o = !out_valid || bundle_ready_i. This is combinational, and is the only path from output to input.
- An accepted 24-bit instruction:
  - If half_open, the open slot is closed (second half 12'h000 = nop) and the index advances first.
  - The instruction is then written to the current slot with flag 0, and the index advances.
- An accepted 12-bit instruction:
  - If half_open, it is written to [11:0] of the open slot, half_open clears and the index advances.
  - Otherwise it is written to [23:12] of the current slot, the flag is set to 1 and half_open is set.
- The bundle closes when any of these holds:
  - the index advances past slot 4;
  - a 24-bit instruction arrives while half_open is set on slot 4. The bundle closes with slot 4 = {first,12'h000}, and the 24-bit instruction lands in slot 0 of the next bundle in the same cycle;
  - flush_i is accepted and the builder is non-empty after including this cycle's instruction.
- Padding on close:
  - Unfilled slots = 24'h000000 with flag 1 (two nops).
  - An open half slot gets [11:0] = 12'h000.
- On close:
  - The bundle moves to the output register and the builder clears.
  - The builder may receive an overflow instruction in the same cycle.
- flush_i with an empty builder and no accepted instruction: no effect.
- flush_i while in_ready_o = 0 is ignored; the source must hold it.
- On each output handshake, bundle_word_addr_o increments by 1 and wraps modulo 2^ADDR_W.
- busy_o = slot index != 0 || half_open.

## Timing
- Reset (async assert, sync-safe deassert by design):
  - bundle_valid_o = 0, bundle_o = 0, bundle_word_addr_o = RESET_WORD_ADDR, busy_o = 0;
  - builder cleared, index 0, half_open 0;
  - in_ready_o = 1 after reset.
- Latency: the closing instruction is accepted in cycle N; bundle_valid_o = 1 in cycle N+1.
- Output handshake:
  - bundle_o and bundle_word_addr_o stay stable while bundle_valid_o=1 && !bundle_ready_i.
  - In a handshake cycle the register may reload with a new bundle, giving back-to-back bundles with no bubble.
- Throughput: one instruction per cycle when the output is not stalled.
- Reset mid-operation discards partial and pending bundles without emitting them.

## Test plan
- Five 24-bit instructions 0x100001..0x100005 -> one bundle:
  - flags 5'b00000;
  - slots = 0x100001, 0x100002, 0x100003, 0x100004, 0x100005;
  - address RESET_WORD_ADDR;
  - valid the cycle after the 5th instruction.
- Ten 12-bit instructions 0x101..0x10A -> flags 5'b11111; slot0 = 0x101102; slot4 = 0x109 10A (i.e. 0x10910A).
- 12-bit 0x1A0 then 24-bit 0x812345 then flush -> flags 5'b10111; slot0 = 0x1A0000; slot1 = 0x812345; slots 2-4 = 0.
- 24-bit ×4, 12-bit 0x301, then 24-bit 0x900007 -> bundle 0 has slot4 = 0x301000, flags 5'b00001. Bundle 1 on flush has slot0 = 0x900007 and the address incremented by 1.
- Hold bundle_ready_i = 0 with a full bundle pending:
  - in_ready_o = 0 and bundle_o is stable for 10 cycles;
  - releasing ready causes the handshake, and the address advances by exactly 1.
- Assert rst_ni low after 3 packed instructions -> all outputs return to reset values, and no bundle is emitted.
